// File: rtl/uart_apb_fifo_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_fifo_regs_if
// Purpose  : APB slave-port bundle for the UART FIFO register block.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_apb_fifo_regs_if #(
    parameter int ADDR_W = 12
);
    logic              psel_i;
    logic              penable_i;
    logic              pwrite_i;
    logic [ADDR_W-1:0] paddr_i;
    logic [31:0]       pwdata_i;
    logic [3:0]        pstrb_i;
    logic [31:0]       prdata_o;
    logic              pready_o;
    logic              pslverr_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        input  prdata_o, pready_o, pslverr_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_apb_fifo_regs.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_fifo_regs
// Purpose  : APB register block for the UART with TX/RX FIFOs, config,
//            interrupt enable/status and a registered interrupt output.
//            Optional macro UART_RX_PARITY_TAG_EN stores a per-char parity tag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_fifo_regs #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int ADDR_W   = 12
) (
    input  logic                clk,
    input  logic                reset,
    uart_apb_fifo_regs_if.slave apb,
    output logic [DATA_W-1:0]   tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    input  logic [DATA_W-1:0]   rx_data_i,
    input  logic                rx_valid_i,
    input  logic                parity_error_i,
    output logic [1:0]          data_bit_num_o,
    output logic                stop_bit_num_o,
    output logic                parity_en_o,
    output logic                parity_type_o,
    output logic                irq_o
);
    localparam int c_tx_aw = $clog2(TX_DEPTH);
    localparam int c_rx_aw = $clog2(RX_DEPTH);
    localparam int c_tx_lw = c_tx_aw + 1;
    localparam int c_rx_lw = c_rx_aw + 1;
`ifdef UART_RX_PARITY_TAG_EN
    localparam int c_rx_w  = DATA_W + 1;
`else
    localparam int c_rx_w  = DATA_W;
`endif
    localparam logic [c_tx_lw-1:0] c_tx_full_lvl = c_tx_lw'(TX_DEPTH);
    localparam logic [c_rx_lw-1:0] c_rx_full_lvl = c_rx_lw'(RX_DEPTH);
    localparam logic [ADDR_W-1:0]  c_a_txdata = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0]  c_a_rxdata = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0]  c_a_cfg    = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0]  c_a_ctrl   = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0]  c_a_stt    = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0]  c_a_ier    = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0]  c_a_isr    = ADDR_W'(8'h18);

    logic [DATA_W-1:0]  r_tx_mem [TX_DEPTH];
    logic [c_tx_aw-1:0] r_tx_wptr, r_tx_rptr;
    logic [c_tx_lw-1:0] r_tx_level;
    logic [c_rx_w-1:0]  r_rx_mem [RX_DEPTH];
    logic [c_rx_aw-1:0] r_rx_wptr, r_rx_rptr;
    logic [c_rx_lw-1:0] r_rx_level;
    logic [4:0]         r_cfg;
    logic               r_tx_en;
    logic [3:0]         r_ier;
    logic [3:1]         r_isr_sticky;
    logic               r_irq;

    logic w_access, w_wr, w_rd, w_err, w_ok_wr, w_ok_rd, w_b0;
    logic w_sel_txdata, w_sel_rxdata, w_sel_cfg, w_sel_ctrl, w_sel_stt, w_sel_ier, w_sel_isr, w_mapped;
    logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic w_tx_push, w_tx_pop, w_tx_flush, w_tx_went_empty;
    logic w_rx_push, w_rx_pop, w_rx_flush, w_rx_ovr;
    logic [c_rx_w-1:0] w_rx_entry, w_rx_head;
    logic [3:0]  w_isr;
    logic [3:1]  w_isr_set, w_isr_clr;
    logic [31:0] w_prdata;
    logic        w_unused;

    assign w_access     = apb.psel_i & apb.penable_i;
    assign w_wr         = w_access & apb.pwrite_i;
    assign w_rd         = w_access & ~apb.pwrite_i;
    assign w_sel_txdata = (apb.paddr_i == c_a_txdata);
    assign w_sel_rxdata = (apb.paddr_i == c_a_rxdata);
    assign w_sel_cfg    = (apb.paddr_i == c_a_cfg);
    assign w_sel_ctrl   = (apb.paddr_i == c_a_ctrl);
    assign w_sel_stt    = (apb.paddr_i == c_a_stt);
    assign w_sel_ier    = (apb.paddr_i == c_a_ier);
    assign w_sel_isr    = (apb.paddr_i == c_a_isr);
    assign w_mapped     = w_sel_txdata | w_sel_rxdata | w_sel_cfg | w_sel_ctrl |
                          w_sel_stt | w_sel_ier | w_sel_isr;

    assign w_tx_empty = (r_tx_level == '0);
    assign w_tx_full  = (r_tx_level == c_tx_full_lvl);
    assign w_rx_empty = (r_rx_level == '0);
    assign w_rx_full  = (r_rx_level == c_rx_full_lvl);

    // An errored access must not touch any state, so every side effect is gated by w_ok_*.
    assign w_err = w_access & (~w_mapped
                 | (w_wr & (w_sel_rxdata | w_sel_stt))
                 | (w_wr & w_sel_txdata & (w_tx_full | ~apb.pstrb_i[0]))
                 | (w_rd & w_sel_rxdata & w_rx_empty));
    assign w_ok_wr = w_wr & ~w_err;
    assign w_ok_rd = w_rd & ~w_err;
    assign w_b0    = w_ok_wr & apb.pstrb_i[0];

    assign tx_valid_o      = ~w_tx_empty & r_tx_en;
    assign tx_data_o       = r_tx_mem[r_tx_rptr];
    assign w_tx_push       = w_ok_wr & w_sel_txdata;
    assign w_tx_pop        = tx_ready_i & tx_valid_o;
    assign w_tx_flush      = w_b0 & w_sel_ctrl & apb.pwdata_i[1];
    assign w_tx_went_empty = w_tx_pop & ~w_tx_push & ~w_tx_flush & (r_tx_level == c_tx_lw'(1));

`ifdef UART_RX_PARITY_TAG_EN
    assign w_rx_entry = {parity_error_i, rx_data_i};
`else
    assign w_rx_entry = rx_data_i;
`endif
    assign w_rx_head  = r_rx_mem[r_rx_rptr];
    assign w_rx_pop   = w_ok_rd & w_sel_rxdata;
    // A full FIFO still accepts a char when the APB side frees the head slot this cycle.
    assign w_rx_push  = rx_valid_i & (~w_rx_full | w_rx_pop);
    assign w_rx_ovr   = rx_valid_i & w_rx_full & ~w_rx_pop;
    assign w_rx_flush = w_b0 & w_sel_ctrl & apb.pwdata_i[2];

    assign w_isr     = {r_isr_sticky, ~w_rx_empty};
    assign w_isr_set = {rx_valid_i & parity_error_i, w_rx_ovr, w_tx_went_empty};
    assign w_isr_clr = (w_b0 & w_sel_isr) ? apb.pwdata_i[3:1] : 3'b000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_level <= '0;
        end else if (w_tx_flush) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_level <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_level <= r_tx_level + 1'b1;
                2'b01:   r_tx_level <= r_tx_level - 1'b1;
                default: r_tx_level <= r_tx_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !w_tx_flush && w_tx_push)
            r_tx_mem[r_tx_wptr] <= apb.pwdata_i[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_level <= '0;
        end else if (w_rx_flush) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_level <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_level <= r_rx_level + 1'b1;
                2'b01:   r_rx_level <= r_rx_level - 1'b1;
                default: r_rx_level <= r_rx_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !w_rx_flush && w_rx_push)
            r_rx_mem[r_rx_wptr] <= w_rx_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg        <= '0;
            r_tx_en      <= 1'b0;
            r_ier        <= '0;
            r_isr_sticky <= '0;
            r_irq        <= 1'b0;
        end else begin
            if (w_b0 & w_sel_cfg)  r_cfg   <= apb.pwdata_i[4:0];
            if (w_b0 & w_sel_ctrl) r_tx_en <= apb.pwdata_i[0];
            if (w_b0 & w_sel_ier)  r_ier   <= apb.pwdata_i[3:0];
            // Set beats a simultaneous clear so no event is lost.
            r_isr_sticky <= (r_isr_sticky & ~w_isr_clr) | w_isr_set;
            r_irq        <= |(w_isr & r_ier);
        end
    end

    always_comb begin
        w_prdata = '0;
        if (w_ok_rd) begin
            if (w_sel_rxdata)      w_prdata[c_rx_w-1:0] = w_rx_head;
            else if (w_sel_cfg)    w_prdata[4:0]        = r_cfg;
            else if (w_sel_ctrl)   w_prdata[0]          = r_tx_en;
            else if (w_sel_stt) begin
                w_prdata[3:0]   = {w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
                w_prdata[15:8]  = 8'(r_tx_level);
                w_prdata[23:16] = 8'(r_rx_level);
            end
            else if (w_sel_ier)    w_prdata[3:0]        = r_ier;
            else if (w_sel_isr)    w_prdata[3:0]        = w_isr;
        end
    end

    assign apb.prdata_o  = w_prdata;
    assign apb.pready_o  = 1'b1;
    assign apb.pslverr_o = w_err;

    assign data_bit_num_o = r_cfg[1:0];
    assign stop_bit_num_o = r_cfg[2];
    assign parity_en_o    = r_cfg[3];
    assign parity_type_o  = r_cfg[4];
    assign irq_o          = r_irq;

    assign w_unused = &{1'b0, apb.pwdata_i[31:DATA_W], apb.pstrb_i[3:1]};
endmodule
`default_nettype wire

// File: tb/tb_uart_apb_fifo_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_apb_fifo_regs
// Purpose  : Scoreboard bench for uart_apb_fifo_regs (APB reads/errors, TX chars).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_apb_fifo_regs;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;
    localparam logic [11:0] A_TXD = 12'h00, A_RXD = 12'h04, A_CFG = 12'h08, A_CTRL = 12'h0C,
                            A_STT = 12'h10, A_IER = 12'h14, A_ISR = 12'h18, A_BAD = 12'h1C;
`ifdef UART_RX_PARITY_TAG_EN
    localparam logic [31:0] EXP_PAR_RD = 32'h0000_0133;
`else
    localparam logic [31:0] EXP_PAR_RD = 32'h0000_0033;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_apb_fifo_regs_if #(.ADDR_W(ADDR_W)) apb_if ();
    logic [DATA_W-1:0] tx_data_o, rx_data_i;
    logic tx_valid_o, tx_ready_i, rx_valid_i, parity_error_i;
    logic [1:0] data_bit_num_o;
    logic stop_bit_num_o, parity_en_o, parity_type_o, irq_o;

    uart_apb_fifo_regs #(.DATA_W(DATA_W), .TX_DEPTH(8), .RX_DEPTH(8), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .apb(apb_if.slave),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .parity_error_i(parity_error_i),
        .data_bit_num_o(data_bit_num_o), .stop_bit_num_o(stop_bit_num_o),
        .parity_en_o(parity_en_o), .parity_type_o(parity_type_o), .irq_o(irq_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0]       apb_q [$];
    string             apb_nm [$];
    logic [DATA_W-1:0] tx_q [$];
    logic [32:0]       mon_e;
    string             mon_nm;
    logic [DATA_W-1:0] mon_tx;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Monitor: every APB access phase and every TX handshake consumes one expectation.
    always @(negedge clk) begin
        if (!reset && apb_if.psel_i && apb_if.penable_i) begin
            if (apb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL apb_unexpected: access at 0x%0h with no expectation", apb_if.paddr_i);
            end else begin
                mon_e  = apb_q.pop_front();
                mon_nm = apb_nm.pop_front();
                chk({mon_nm, "_rdata"}, apb_if.prdata_o, mon_e[32:1]);
                chk({mon_nm, "_err"}, {31'b0, apb_if.pslverr_o}, {31'b0, mon_e[0]});
                chk({mon_nm, "_ready"}, {31'b0, apb_if.pready_o}, 32'd1);
            end
        end
        if (!reset && tx_valid_o && tx_ready_i) begin
            if (tx_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL tx_unexpected: char 0x%0h with no expectation", tx_data_o);
            end else begin
                mon_tx = tx_q.pop_front();
                chk("tx_char", {24'b0, tx_data_o}, {24'b0, mon_tx});
            end
        end
    end

    task automatic apb_xfer(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                            input logic [3:0] st, input logic [31:0] exp_rd, input bit exp_err,
                            input string nm, input bit rxp, input logic [7:0] rxd);
        @(posedge clk); #1;
        apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b0; apb_if.pwrite_i = wr;
        apb_if.paddr_i = a; apb_if.pwdata_i = wd; apb_if.pstrb_i = st;
        apb_q.push_back({exp_rd, exp_err});
        apb_nm.push_back(nm);
        @(posedge clk); #1;
        apb_if.penable_i = 1'b1;
        if (rxp) begin rx_valid_i = 1'b1; rx_data_i = rxd; end
        @(posedge clk); #1;
        apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
        rx_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input bit exp_err, input string nm);
        apb_xfer(1'b1, a, wd, st, 32'h0, exp_err, nm, 1'b0, 8'h0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input bit exp_err, input string nm);
        apb_xfer(1'b0, a, 32'h0, 4'hF, exp, exp_err, nm, 1'b0, 8'h0);
    endtask

    task automatic tx_pulse(input bit expect_char, input logic [7:0] c);
        @(posedge clk); #1;
        if (expect_char) tx_q.push_back(c);
        tx_ready_i = 1'b1;
        @(posedge clk); #1;
        tx_ready_i = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d, input bit perr);
        @(posedge clk); #1;
        rx_valid_i = 1'b1; rx_data_i = d; parity_error_i = perr;
        @(posedge clk); #1;
        rx_valid_i = 1'b0; parity_error_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
        apb_if.paddr_i = '0; apb_if.pwdata_i = '0; apb_if.pstrb_i = '0;
        tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0; parity_error_i = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        chk("rst_pslverr", {31'b0, apb_if.pslverr_o}, 32'd0);
        chk("rst_prdata", apb_if.prdata_o, 32'd0);
        rd(A_STT, 32'h5, 1'b0, "rst_stt");
        rd(A_CFG, 32'h0, 1'b0, "rst_cfg");
        rd(A_CTRL, 32'h0, 1'b0, "rst_ctrl");
        rd(A_IER, 32'h0, 1'b0, "rst_ier");
        rd(A_ISR, 32'h0, 1'b0, "rst_isr");

        // Configuration with byte strobes
        wr(A_CFG, 32'h1D, 4'b0001, 1'b0, "cfg_wr");
        @(negedge clk);
        chk("cfg_out", {27'b0, data_bit_num_o, stop_bit_num_o, parity_en_o, parity_type_o}, 32'b01111);
        wr(A_CFG, 32'h00, 4'b0010, 1'b0, "cfg_wr_nostrb");
        rd(A_CFG, 32'h1D, 1'b0, "cfg_rd");
        rd(A_STT, 32'h5, 1'b0, "cfg_stt");

        // TX path
        wr(A_TXD, 32'h41, 4'hF, 1'b0, "tx_push41");
        wr(A_TXD, 32'h42, 4'hF, 1'b0, "tx_push42");
        rd(A_STT, 32'h204, 1'b0, "stt_tx2");
        @(negedge clk);
        chk("tx_valid_disabled", {31'b0, tx_valid_o}, 32'd0);
        wr(A_TXD, 32'h43, 4'b0010, 1'b1, "tx_push_nostrb");
        rd(A_STT, 32'h204, 1'b0, "stt_tx2_after_err");
        wr(A_CTRL, 32'h1, 4'hF, 1'b0, "ctrl_txen");
        @(negedge clk);
        chk("tx_valid_en", {31'b0, tx_valid_o}, 32'd1);
        tx_pulse(1'b1, 8'h41);
        tx_pulse(1'b1, 8'h42);
        rd(A_ISR, 32'h2, 1'b0, "isr_tx_empty");
        wr(A_ISR, 32'h2, 4'hF, 1'b0, "isr_w1c_tx");
        rd(A_ISR, 32'h0, 1'b0, "isr_after_w1c");
        tx_pulse(1'b0, 8'h00);
        rd(A_STT, 32'h5, 1'b0, "stt_ready_ignored");
        rd(A_ISR, 32'h0, 1'b0, "isr_ready_ignored");

        for (int i = 0; i < 8; i++) wr(A_TXD, 32'h10 + i, 4'hF, 1'b0, "tx_fill");
        rd(A_STT, 32'h806, 1'b0, "stt_tx_full");
        wr(A_TXD, 32'hEE, 4'hF, 1'b1, "tx_push_full");
        rd(A_STT, 32'h806, 1'b0, "stt_tx_full_kept");
        tx_pulse(1'b1, 8'h10);
        rd(A_STT, 32'h704, 1'b0, "stt_tx7");
        wr(A_CTRL, 32'h3, 4'hF, 1'b0, "tx_flush");
        rd(A_STT, 32'h5, 1'b0, "stt_tx_flushed");
        rd(A_ISR, 32'h0, 1'b0, "isr_flush_no_set");
        rd(A_CTRL, 32'h1, 1'b0, "ctrl_selfclear");

        // RX path: overflow, ordering, pop+push when full, empty read
        for (int i = 0; i < 9; i++) rx_push(8'h60 + 8'(i), 1'b0);
        rd(A_STT, 32'h0008_0009, 1'b0, "stt_rx_full");
        rd(A_ISR, 32'h5, 1'b0, "isr_rx_ovr");
        rd(A_RXD, 32'h60, 1'b0, "rx_first");
        rd(A_STT, 32'h0007_0001, 1'b0, "stt_rx7");
        rx_push(8'h69, 1'b0);
        wr(A_ISR, 32'h4, 4'hF, 1'b0, "isr_w1c_ovr");
        rd(A_ISR, 32'h1, 1'b0, "isr_ovr_cleared");
        apb_xfer(1'b0, A_RXD, 32'h0, 4'hF, 32'h61, 1'b0, "rx_pop_push_full", 1'b1, 8'h55);
        rd(A_STT, 32'h0008_0009, 1'b0, "stt_rx_still_full");
        rd(A_ISR, 32'h1, 1'b0, "isr_no_ovr");
        for (int i = 2; i < 8; i++) rd(A_RXD, 32'h60 + i, 1'b0, "rx_drain");
        rd(A_RXD, 32'h69, 1'b0, "rx_drain69");
        rd(A_RXD, 32'h55, 1'b0, "rx_last");
        rd(A_RXD, 32'h0, 1'b1, "rx_empty_rd");
        rd(A_ISR, 32'h0, 1'b0, "isr_rx_empty");
        rd(A_STT, 32'h5, 1'b0, "stt_rx_empty");

        // Interrupts and parity tagging
        wr(A_IER, 32'h1, 4'hF, 1'b0, "ier_wr1");
        rx_push(8'h33, 1'b1);
        @(negedge clk);
        chk("irq_lag", {31'b0, irq_o}, 32'd0);
        @(negedge clk);
        chk("irq_rx_avail", {31'b0, irq_o}, 32'd1);
        rd(A_ISR, 32'h9, 1'b0, "isr_par");
        rd(A_RXD, EXP_PAR_RD, 1'b0, "rx_par_tag");
        repeat (2) @(negedge clk);
        chk("irq_masked", {31'b0, irq_o}, 32'd0);
        wr(A_IER, 32'h8, 4'hF, 1'b0, "ier_wr8");
        repeat (2) @(negedge clk);
        chk("irq_par", {31'b0, irq_o}, 32'd1);
        wr(A_ISR, 32'h8, 4'hF, 1'b0, "isr_w1c_par");
        repeat (2) @(negedge clk);
        chk("irq_cleared", {31'b0, irq_o}, 32'd0);
        rd(A_ISR, 32'h0, 1'b0, "isr_par_cleared");
        wr(A_IER, 32'h0, 4'hF, 1'b0, "ier_wr0");

        // RX flush racing an incoming char
        rx_push(8'h44, 1'b0);
        apb_xfer(1'b1, A_CTRL, 32'h5, 4'hF, 32'h0, 1'b0, "rx_flush", 1'b1, 8'h77);
        rd(A_STT, 32'h5, 1'b0, "stt_rx_flushed");
        rd(A_CTRL, 32'h1, 1'b0, "ctrl_after_rxflush");

        // Error responses
        rd(A_BAD, 32'h0, 1'b1, "rd_unmapped");
        wr(A_BAD, 32'hFF, 4'hF, 1'b1, "wr_unmapped");
        wr(A_STT, 32'hFF, 4'hF, 1'b1, "wr_stt");
        wr(A_RXD, 32'hFF, 4'hF, 1'b1, "wr_rxdata");
        rd(A_TXD, 32'h0, 1'b0, "rd_txdata");
        rd(A_STT, 32'h5, 1'b0, "stt_after_errs");

        // Reset in the middle of activity
        wr(A_TXD, 32'hAA, 4'hF, 1'b0, "pre_rst_tx");
        rx_push(8'hBB, 1'b0);
        @(negedge clk);
        chk("pre_rst_tx_valid", {31'b0, tx_valid_o}, 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        chk("mid_rst_cfg_out", {27'b0, data_bit_num_o, stop_bit_num_o, parity_en_o, parity_type_o}, 32'd0);
        rd(A_STT, 32'h5, 1'b0, "mid_rst_stt");
        rd(A_CTRL, 32'h0, 1'b0, "mid_rst_ctrl");
        rd(A_ISR, 32'h0, 1'b0, "mid_rst_isr");

        repeat (2) @(posedge clk);
        chk("sb_drain", apb_q.size() + tx_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_apb_fifo_regs.md
Name: uart_apb_fifo_regs

Overview:
Parametrised APB register block for the UART that replaces single TX/RX data registers with a TX FIFO and an RX FIFO. It adds byte-strobe-qualified config writes, an interrupt enable/status pair with write-1-to-clear, error responses on APB, and a single interrupt output. It sits between the APB slave port and the UART TX/RX engines and drives their configuration inputs.

Parameters:
DATA_W, 8, UART character width; FIFO entry data width (5..9 allowed)
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)
ADDR_W, 12, APB address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
paddr_i  in  ADDR_W  APB address (byte)
pwdata_i  in  32  APB write data
pstrb_i  in  4  APB byte strobes
prdata_o  out  32  APB read data
pready_o  out  1  APB ready (tied 1, zero wait)
pslverr_o  out  1  APB error, valid in access phase
tx_data_o  out  DATA_W  TX FIFO head
tx_valid_o  out  1  TX FIFO non-empty and CTRL.TX_EN=1
tx_ready_i  in  1  1-cycle pulse: UART took head char
rx_data_i  in  DATA_W  received char
rx_valid_i  in  1  1-cycle pulse: rx_data_i valid
parity_error_i  in  1  parity error for char, qualified by rx_valid_i
data_bit_num_o  out  2  CFG[1:0]
stop_bit_num_o  out  1  CFG[2]
parity_en_o  out  1  CFG[3]
parity_type_o  out  1  CFG[4]
irq_o  out  1  |(ISR & IER), registered

Behaviour:
- Access = psel_i & penable_i; acts in that cycle only. prdata_o combinational from current state; 0 when no read access.
- Map: 0x00 TXDATA (W: push pwdata_i[DATA_W-1:0], needs pstrb_i[0]; R: 0). 0x04 RXDATA (R: {.., tag, data} of head, pops). 0x08 CFG (RW, [4:0], per-byte strobe, byte0 only meaningful). 0x0C CTRL (bit0 TX_EN RW; bit1 TX_FLUSH, bit2 RX_FLUSH write-1 self-clearing, read 0). 0x10 STT (RO: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [15:8] tx_level, [23:16] rx_level). 0x14 IER (RW [3:0]). 0x18 ISR (R; W1C [3:0]).
- ISR bits: [0] RX_AVAIL level = !rx_empty (not clearable); [1] TX_EMPTY sticky, set on transition to empty by tx_ready_i pop; [2] RX_OVR sticky; [3] PAR_ERR sticky, set on rx_valid_i & parity_error_i.
- pslverr_o=1 on: unmapped address; write to 0x04 or 0x10; TXDATA write when tx_full or pstrb_i[0]=0; RXDATA read when rx_empty. Errored access changes no state; read data 0.
- TX pop on tx_ready_i & tx_valid_o; tx_ready_i while !tx_valid_o ignored. Push+pop same cycle allowed even when full? No: push while full errors regardless of simultaneous pop.
- RX push on rx_valid_i. Full: if APB pop same cycle, push accepted, level unchanged; else char dropped, RX_OVR set.
- Flush same cycle as push/pop: flush wins, level 0, pending push discarded; sticky bits unaffected.
- Levels are $clog2(DEPTH)+1 bits, zero-extended into STT fields; pointers wrap mod DEPTH.
- irq_o one cycle after ISR/IER change.
- Reset: FIFOs empty, CFG=0, CTRL=0, IER=0, ISR sticky=0, irq_o=0, tx_valid_o=0, pslverr_o=0, prdata_o=0; reset mid-transfer discards all FIFO contents.

Optional Feature:
UART_RX_PARITY_TAG_EN: defined -> RX FIFO entries DATA_W+1 bits, storing parity_error_i per char; RXDATA bit[DATA_W] returns that entry's tag. Undefined -> entries DATA_W bits, RXDATA bit[DATA_W] reads 0; only sticky ISR.PAR_ERR reports parity errors.

Test Plan:
Reset, write CFG=0x1D strobe 0001 -> data_bit_num_o=1, stop=1, parity_en=1, type=1; STT=0x00000005.
TX_EN=0, push 0x41,0x42 -> STT tx_level=2, tx_valid_o=0; set TX_EN, two tx_ready_i -> tx_data_o 0x41 then 0x42, ISR[1]=1, W1C 0x2 clears it.
Push TX_DEPTH chars, one more write -> pslverr_o=1, tx_level stays TX_DEPTH.
RX_DEPTH+1 rx_valid_i with no reads -> rx_full=1, ISR[2]=1, first RXDATA read returns first char; empty read -> pslverr_o=1, prdata_o=0.
RX full, rx_valid_i 0x55 same cycle as RXDATA read -> read returns oldest, level stays RX_DEPTH, ISR[2] unchanged, last entry 0x55.
IER=0x1, rx_valid_i 0x33 parity_error_i=1 -> irq_o=1 next cycle, ISR[3]=1, RXDATA=0x133 with macro / 0x033 without; RX_FLUSH with rx_valid_i same cycle -> rx_level=0.
